// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace serializer.
package commit_trace_pkg;

  localparam int unsigned ORDER_W = 10;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSN_W  = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSN_W-1:0]  insn;
    logic [ORDER_W-1:0] order;
    logic               trap;
    logic               halt;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_e;

endpackage

// File: rtl/trace_mpush_fifo.sv
// Multi-write, single-read FIFO holding packed retire entries.
module trace_mpush_fifo
  import commit_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$clog2(NRET+1)-1:0]        push_n,
  input  trace_entry_t [NRET-1:0]          push_data,
  input  logic                             pop,
  output logic [$clog2(DEPTH):0]           count,
  output trace_entry_t                     head
);

  localparam int unsigned KW = $clog2(NRET + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  trace_entry_t    mem_q [DEPTH];
  trace_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Write the first push_n packed entries at consecutive slots; advance pointers.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NRET; i++) begin
      if (KW'(i) < push_n) begin
        mem_d[PW'(wr_ptr_q + PW'(i))] = push_data[i];
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_n) - CW'(pop);
  end

  // Storage and pointer registers; reset empties and zeroes the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/commit_trace_serializer.sv
// Packs multi-lane retire trace into a single valid/ready stream with halt drain.
module commit_trace_serializer
  import commit_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRET-1:0]         commit_valid,
  input  logic [NRET*XLEN-1:0]    commit_pc,
  input  logic [NRET*32-1:0]      commit_insn,
  input  logic [NRET*10-1:0]      commit_order,
  input  logic [NRET-1:0]         trap_valid,
  input  logic [NRET-1:0]         sim_halt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_insn,
  output logic [9:0]              out_order,
  output logic                    out_trap,
  output logic                    out_halt,
  output logic                    overflow,
  output logic [15:0]             drop_cnt,
  output logic                    order_err,
  output logic                    done
);

  localparam int unsigned KW = $clog2(NRET + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  trace_state_e              state_q, state_d;
  logic                      overflow_q, overflow_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;
  logic                      order_err_q, order_err_d;
  logic [ORDER_W-1:0]        expected_q, expected_d;

  trace_entry_t [NRET-1:0]   grp;
  logic [KW-1:0]             grp_n;
  logic                      grp_halt;
  logic [KW-1:0]             push_n;
  logic [16:0]               drop_sum;
  logic                      pop;
  logic [CW-1:0]             fifo_count;
  trace_entry_t              head;

  trace_mpush_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_n    (push_n),
    .push_data (grp),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  // Lane packer: valid lanes in ascending order, truncated after the first halt lane.
  always_comb begin
    int unsigned n;
    n        = 0;
    grp      = '0;
    grp_halt = 1'b0;
    if (state_q == RUN) begin
      for (int i = 0; i < NRET; i++) begin
        if (commit_valid[i] && !grp_halt) begin
          grp[n] = '{pc:    PC_W'(commit_pc[i*XLEN +: XLEN]),
                     insn:  commit_insn[i*32 +: 32],
                     order: commit_order[i*ORDER_W +: ORDER_W],
                     trap:  trap_valid[i],
                     halt:  sim_halt[i]};
          n++;
          grp_halt = sim_halt[i];
        end
      end
    end
    grp_n = KW'(n);
  end

  assign out_valid = (fifo_count != '0) && (state_q != DONE);
  assign pop       = out_valid && out_ready;

  // Capacity check, drop accounting, order checker and RUN/DRAIN/DONE sequencing.
  always_comb begin
    state_d     = state_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    order_err_d = order_err_q;
    expected_d  = expected_q;
    push_n      = '0;
    drop_sum    = '0;
    if (grp_n != '0) begin
      // Free space is judged at start of cycle; a same-cycle pop earns no credit.
      if (32'(grp_n) + 32'(fifo_count) <= DEPTH) begin
        push_n = grp_n;
        if (grp_halt) state_d = DRAIN;
      end else begin
        overflow_d = 1'b1;
        drop_sum   = 17'(drop_cnt_q) + 17'(grp_n);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
    if (pop) begin
      if (head.order != expected_q) order_err_d = 1'b1;
      expected_d = head.order + ORDER_W'(1);
      if (head.halt) state_d = DONE;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      order_err_q <= 1'b0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      order_err_q <= order_err_d;
      expected_q  <= expected_d;
    end
  end

  assign out_pc    = XLEN'(head.pc);
  assign out_insn  = head.insn;
  assign out_order = head.order;
  assign out_trap  = head.trap;
  assign out_halt  = head.halt;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign order_err = order_err_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed + randomized bench for commit_trace_serializer against a queue model.
module tb_commit_trace_serializer;

  localparam int NRET  = 2;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NRET-1:0]      commit_valid, trap_valid, sim_halt;
  logic [NRET*XLEN-1:0] commit_pc;
  logic [NRET*32-1:0]   commit_insn;
  logic [NRET*10-1:0]   commit_order;
  logic                 out_valid, out_ready, out_trap, out_halt;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_insn;
  logic [9:0]           out_order;
  logic                 overflow, order_err, done;
  logic [15:0]          drop_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model: a queue of entries plus scalar status.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic [9:0]  order;
    logic        trap;
    logic        halt;
  } ent_t;

  ent_t mq[$];
  int   m_phase;      // 0 running, 1 draining, 2 closed
  int   m_exp;
  bit   m_ovf, m_oerr;
  int   m_drop;
  int   ord;

  commit_trace_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_insn  (commit_insn),
    .commit_order (commit_order),
    .trap_valid   (trap_valid),
    .sim_halt     (sim_halt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_insn     (out_insn),
    .out_order    (out_order),
    .out_trap     (out_trap),
    .out_halt     (out_halt),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .order_err    (order_err),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_phase = 0; m_exp = 0; m_ovf = 0; m_oerr = 0; m_drop = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    ent_t grp[$];
    ent_t e;
    bit   hlt = 0;
    bit   accept = 0;
    bit   pop;
    pop = (mq.size() > 0) && (m_phase != 2) && out_ready;
    if (m_phase == 0) begin
      for (int i = 0; i < NRET; i++) begin
        if (commit_valid[i] && !hlt) begin
          e.pc    = commit_pc[i*XLEN +: XLEN];
          e.insn  = commit_insn[i*32 +: 32];
          e.order = commit_order[i*10 +: 10];
          e.trap  = trap_valid[i];
          e.halt  = sim_halt[i];
          grp.push_back(e);
          hlt = sim_halt[i];
        end
      end
    end
    if (grp.size() > 0) begin
      if (mq.size() + grp.size() <= DEPTH) accept = 1;
      else begin
        m_ovf  = 1;
        m_drop = (m_drop + grp.size() > 65535) ? 65535 : m_drop + grp.size();
      end
    end
    if (pop) begin
      e = mq.pop_front();
      if (int'(e.order) != m_exp) m_oerr = 1;
      m_exp = (int'(e.order) + 1) % 1024;
      if (e.halt) m_phase = 2;
    end
    if (accept) begin
      foreach (grp[j]) mq.push_back(grp[j]);
      if (hlt) m_phase = 1;
    end
  endtask

  task automatic check_all();
    bit mv;
    mv = (mq.size() > 0) && (m_phase != 2);
    chk("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      chk("out_pc",    out_pc,           mq[0].pc);
      chk("out_insn",  64'(out_insn),    64'(mq[0].insn));
      chk("out_order", 64'(out_order),   64'(mq[0].order));
      chk("out_trap",  64'(out_trap),    64'(mq[0].trap));
      chk("out_halt",  64'(out_halt),    64'(mq[0].halt));
    end
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    chk("order_err", 64'(order_err), 64'(m_oerr));
    chk("done",      64'(done),      64'(m_phase == 2));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Clear all lanes; junk on invalid lanes must be ignored.
  task automatic idle();
    commit_valid = '0;
    trap_valid   = NRET'($urandom);
    sim_halt     = NRET'($urandom);
    commit_pc    = {$urandom, $urandom, $urandom, $urandom};
    commit_insn  = {$urandom, $urandom};
    commit_order = 20'($urandom);
  endtask

  task automatic lane(input int i, input int o, input bit tr, input bit h);
    commit_valid[i]          = 1'b1;
    commit_pc[i*XLEN +: XLEN] = {$urandom, $urandom};
    commit_insn[i*32 +: 32]  = $urandom;
    commit_order[i*10 +: 10] = 10'(o);
    trap_valid[i]            = tr;
    sim_halt[i]              = h;
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc",    out_pc,         64'd0);
    chk("rst_out_insn",  64'(out_insn),  64'd0);
    chk("rst_out_order", 64'(out_order), 64'd0);
    chk("rst_out_trap",  64'(out_trap),  64'd0);
    chk("rst_out_halt",  64'(out_halt),  64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_done",      64'(done),      64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single lane, orders 0..5, consumer always ready.
    out_ready = 1'b1;
    for (int o = 0; o < 6; o++) begin
      idle(); lane(0, o, 0, 0); step();
    end
    idle();
    repeat (3) step();

    // Both lanes for 8 cycles with consumer stalled: half buffered, half dropped.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      idle(); lane(0, 2*c, 0, 0); lane(1, 2*c+1, 0, 0); step();
    end
    idle(); out_ready = 1'b1;
    repeat (10) step();

    // Order discontinuity 0,1,5,6 flags once.
    do_reset();
    out_ready = 1'b1;
    begin
      int seq [4] = '{0, 1, 5, 6};
      foreach (seq[j]) begin idle(); lane(0, seq[j], 0, 0); step(); end
    end
    idle();
    repeat (3) step();

    // Wrap 1022,1023,0,1 with a trap on 1023.
    do_reset();
    out_ready = 1'b1;
    idle(); lane(0, 1022, 0, 0); step();
    idle(); lane(0, 1023, 1, 0); lane(1, 0, 0, 0); step();
    idle(); lane(0, 1, 0, 0); step();
    idle();
    repeat (3) step();

    // Halt on lane 0 discards lane 1; later commits ignored; done after pop.
    do_reset();
    out_ready = 1'b1;
    for (int o = 0; o < 3; o++) begin idle(); lane(0, o, 0, 0); step(); end
    idle(); lane(0, 3, 0, 1); lane(1, 4, 0, 0); step();
    for (int c = 0; c < 5; c++) begin
      idle(); lane(0, 5 + 2*c, 0, 0); lane(1, 6 + 2*c, 0, 0); step();
    end

    // Reset mid-drain with 5 entries buffered, then a fresh order 0.
    do_reset();
    out_ready = 1'b0;
    for (int o = 0; o < 4; o++) begin idle(); lane(0, o, 0, 0); step(); end
    idle(); lane(0, 4, 0, 1); step();
    idle(); step();
    do_reset();
    out_ready = 1'b1;
    idle(); lane(0, 0, 0, 0); step();
    idle(); repeat (2) step();

    // Random traffic crossing the order wrap, with stalls, traps and skips.
    do_reset();
    ord = 1016;
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int i = 0; i < NRET; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          lane(i, ord, $urandom_range(7, 0) == 0, 0);
          ord = (ord + 1) % 1024;
          if ($urandom_range(19, 0) == 0) ord = (ord + 3) % 1024;
        end
      end
      out_ready = ($urandom_range(2, 0) != 0);
      step();
    end

    // Close the random stream with a halt and drain to done.
    out_ready = 1'b1;
    for (int a = 0; a < 20 && m_phase == 0; a++) begin
      idle(); lane(0, ord, 0, 1); lane(1, (ord + 1) % 1024, 0, 0); step();
    end
    for (int a = 0; a < DEPTH + 6 && m_phase != 2; a++) begin
      idle();
      if ($urandom_range(1, 0) == 1) lane(0, ord + 2, 0, 0);
      step();
    end
    chk("final_done", 64'(done), 64'd1);
    idle(); repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
